// File: rtl/fp_pkg.sv
// Shared floating-point definitions: default field widths, operand classes,
// exponent bias and the canonical quiet NaN pattern.
package fp_pkg;

   localparam int DEF_EXP_W = 5;
   localparam int DEF_MAN_W = 10;

   typedef enum logic [1:0] {
      CLS_ZERO,
      CLS_NORM,
      CLS_INF,
      CLS_NAN
   } fp_class_e;

   function automatic int expBias(input int expW);
      return (1 << (expW - 1)) - 1;
   endfunction

   // Returned in the low 1+expW+manW bits; callers cast down to their word width.
   function automatic logic [63:0] qnanBits(input int expW, input int manW);
      logic [63:0] ones;
      ones = (64'd1 << expW) - 64'd1;
      return (ones << manW) | (64'd1 << (manW - 1));
   endfunction

   function automatic fp_class_e classify(input logic expZero, input logic expOnes,
                                          input logic manZero);
      if (expZero) begin
         return CLS_ZERO;
      end
      if (expOnes) begin
         return manZero ? CLS_INF : CLS_NAN;
      end
      return CLS_NORM;
   endfunction

endpackage

// File: rtl/fp_mult_pipe_if.sv
// Operand/result handshake bundle for the pipelined multiplier.
interface fp_mult_pipe_if #(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10
);
   logic                   in_valid;
   logic                   in_ready;
   logic [EXP_W+MAN_W:0]   in_a;
   logic [EXP_W+MAN_W:0]   in_b;
   logic                   out_valid;
   logic                   out_ready;
   logic [EXP_W+MAN_W:0]   out_p;
   logic [3:0]             out_flags;

   modport master (
      output in_valid, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_p, out_flags
   );

   modport slave (
      input  in_valid, in_a, in_b, out_ready,
      output in_ready, out_valid, out_p, out_flags
   );
endinterface

// File: rtl/fp_round_pack.sv
// Normalise, round-to-nearest-even and pack a raw significand product into a
// result word with {invalid, overflow, underflow, inexact} flags.
module fp_round_pack
   import fp_pkg::*;
#(
   parameter int EXP_W = DEF_EXP_W,
   parameter int MAN_W = DEF_MAN_W
) (
   input  logic                      sign_i,
   input  logic signed [EXP_W+1:0]   exp_i,
   input  logic [2*MAN_W+1:0]        prod_i,
   input  fp_class_e                 cls_i,
   input  logic                      invalid_i,
   output logic [EXP_W+MAN_W:0]      p_o,
   output logic [3:0]                flags_o
);

   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int XW = EXP_W + 2;
   localparam logic [W-1:0]          QNAN     = W'(qnanBits(EXP_W, MAN_W));
   localparam logic signed [XW-1:0]  EXP_MAX  = {2'b00, {EXP_W{1'b1}}};
   localparam logic signed [XW-1:0]  EXP_ZERO = '0;

   logic [2*MAN_W:0]        shifted;
   logic signed [XW-1:0]    expNorm;
   logic [MAN_W-1:0]        mant;
   logic                    guard;
   logic                    sticky;
   logic                    roundUp;
   logic [MAN_W:0]          mantRnd;
   logic signed [XW-1:0]    expFinal;
   logic                    inexact;

   // The hidden bit sits at the top of the shifted word and is dropped; a set
   // product MSB means the significand product reached [2,4) and needs one
   // extra exponent step.
   always_comb begin
      shifted  = prod_i[2*MAN_W+1] ? prod_i[2*MAN_W:0] : {prod_i[2*MAN_W-1:0], 1'b0};
      expNorm  = exp_i + {{(XW-1){1'b0}}, prod_i[2*MAN_W+1]};
      mant     = shifted[2*MAN_W:MAN_W+1];
      guard    = shifted[MAN_W];
      sticky   = |shifted[MAN_W-1:0];
      roundUp  = guard & (sticky | mant[0]);
      mantRnd  = {1'b0, mant} + {{MAN_W{1'b0}}, roundUp};
      expFinal = expNorm + {{(XW-1){1'b0}}, mantRnd[MAN_W]};
      inexact  = guard | sticky;
   end

   // Range checks happen after rounding, so a carry-out can itself overflow.
   always_comb begin
      p_o     = '0;
      flags_o = '0;
      case (cls_i)
         CLS_ZERO: begin
            p_o = {sign_i, {(W-1){1'b0}}};
         end
         CLS_INF: begin
            p_o = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         end
         CLS_NAN: begin
            p_o     = QNAN;
            flags_o = {invalid_i, 3'b000};
         end
         default: begin
            if (expFinal >= EXP_MAX) begin
               p_o     = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
               flags_o = 4'b0101;
            end else if (expFinal <= EXP_ZERO) begin
               p_o     = {sign_i, {(W-1){1'b0}}};
               flags_o = 4'b0011;
            end else begin
               p_o     = {sign_i, expFinal[EXP_W-1:0], mantRnd[MAN_W-1:0]};
               flags_o = {3'b000, inexact};
            end
         end
      endcase
   end

endmodule

// File: rtl/fp_mult_pipe.sv
// Three-stage floating-point multiplier: classify/exponent, significand
// multiply, then round/pack, all advancing together under one global stall.
module fp_mult_pipe
   import fp_pkg::*;
#(
   parameter int EXP_W = DEF_EXP_W,
   parameter int MAN_W = DEF_MAN_W
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [EXP_W+MAN_W:0]    in_a,
   input  logic [EXP_W+MAN_W:0]    in_b,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [EXP_W+MAN_W:0]    out_p,
   output logic [3:0]              out_flags
);

   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int XW = EXP_W + 2;
   localparam int PW = 2 * MAN_W + 2;
   localparam logic signed [XW-1:0] BIAS = XW'(expBias(EXP_W));

   logic [EXP_W-1:0]       expA, expB;
   logic [MAN_W-1:0]       manA, manB;
   fp_class_e              clsA, clsB;

   logic                   s1Sign_d;
   logic signed [XW-1:0]   s1Exp_d;
   fp_class_e              s1Cls_d;
   logic                   s1Inv_d;

   logic                   s1Valid_q, s2Valid_q, outValid_q;
   logic                   s1Sign_q, s2Sign_q;
   logic signed [XW-1:0]   s1Exp_q, s2Exp_q;
   fp_class_e              s1Cls_q, s2Cls_q;
   logic                   s1Inv_q, s2Inv_q;
   logic [MAN_W:0]         s1SigA_q, s1SigB_q;
   logic [PW-1:0]          s2Prod_d, s2Prod_q;
   logic [W-1:0]           outP_d, outP_q;
   logic [3:0]             outFlags_d, outFlags_q;
   logic                   en;

   assign en        = !outValid_q || out_ready;
   assign in_ready  = en;
   assign out_valid = outValid_q;
   assign out_p     = outP_q;
   assign out_flags = outFlags_q;

   assign expA = in_a[W-2:MAN_W];
   assign expB = in_b[W-2:MAN_W];
   assign manA = in_a[MAN_W-1:0];
   assign manB = in_b[MAN_W-1:0];
   assign clsA = classify(expA == '0, &expA, manA == '0);
   assign clsB = classify(expB == '0, &expB, manB == '0);

   // Special cases are resolved up front so later stages only carry a result
   // class; NaN outranks everything, and zero times infinity is the one
   // invalid combination.
   always_comb begin
      s1Sign_d = in_a[W-1] ^ in_b[W-1];
      s1Exp_d  = XW'(expA) + XW'(expB) - BIAS;
      s1Cls_d  = CLS_NORM;
      s1Inv_d  = 1'b0;
      if (clsA == CLS_NAN || clsB == CLS_NAN) begin
         s1Cls_d = CLS_NAN;
      end else if ((clsA == CLS_ZERO && clsB == CLS_INF) ||
                   (clsA == CLS_INF && clsB == CLS_ZERO)) begin
         s1Cls_d = CLS_NAN;
         s1Inv_d = 1'b1;
      end else if (clsA == CLS_INF || clsB == CLS_INF) begin
         s1Cls_d = CLS_INF;
      end else if (clsA == CLS_ZERO || clsB == CLS_ZERO) begin
         s1Cls_d = CLS_ZERO;
      end
   end

   assign s2Prod_d = s1SigA_q * s1SigB_q;

   fp_round_pack #(
      .EXP_W(EXP_W),
      .MAN_W(MAN_W)
   ) u_roundPack (
      .sign_i   (s2Sign_q),
      .exp_i    (s2Exp_q),
      .prod_i   (s2Prod_q),
      .cls_i    (s2Cls_q),
      .invalid_i(s2Inv_q),
      .p_o      (outP_d),
      .flags_o  (outFlags_d)
   );

   // Control and visible outputs reset; reset drops anything in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1Valid_q  <= 1'b0;
         s2Valid_q  <= 1'b0;
         outValid_q <= 1'b0;
         outP_q     <= '0;
         outFlags_q <= '0;
      end else if (en) begin
         s1Valid_q  <= in_valid;
         s2Valid_q  <= s1Valid_q;
         outValid_q <= s2Valid_q;
         outP_q     <= outP_d;
         outFlags_q <= outFlags_d;
      end
   end

   always_ff @(posedge clk) begin
      if (en) begin
         s1Sign_q <= s1Sign_d;
         s1Exp_q  <= s1Exp_d;
         s1Cls_q  <= s1Cls_d;
         s1Inv_q  <= s1Inv_d;
         s1SigA_q <= {1'b1, manA};
         s1SigB_q <= {1'b1, manB};
         s2Sign_q <= s1Sign_q;
         s2Exp_q  <= s1Exp_q;
         s2Cls_q  <= s1Cls_q;
         s2Inv_q  <= s1Inv_q;
         s2Prod_q <= s2Prod_d;
      end
   end

endmodule
